// File: rtl/rob_pkg.sv
// rtl/rob_pkg.sv - reorder buffer sizing, tag widths and entry types shared with rs and lsq
package rob_pkg;

  localparam int ROB_DEPTH  = 64;
  localparam int ROB_IDX_W  = $clog2(ROB_DEPTH);
  localparam int PREG_WIDTH = 6;
  localparam int AREG_WIDTH = 5;
  localparam int PC_WIDTH   = 12;
  localparam int NUM_CMP    = 3;

  typedef logic [ROB_IDX_W-1:0] rob_idx_t;

  typedef struct packed {
    logic                  reg_write;
    logic [AREG_WIDTH-1:0] rd_arch;
    logic [PREG_WIDTH-1:0] rd_phys;
    logic [PREG_WIDTH-1:0] old_rd;
    logic [PC_WIDTH-1:0]   pc;
  } rob_payload_t;

  typedef struct packed {
    logic         valid;
    logic         done;
    rob_payload_t data;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_if.sv
// rtl/reorder_buffer_if.sv - dispatch, completion, retire and occupancy signals of the reorder buffer
interface reorder_buffer_if;
  import rob_pkg::*;

  logic                         alloc_valid;
  logic                         alloc_reg_write;
  logic [AREG_WIDTH-1:0]        alloc_rd_arch;
  logic [PREG_WIDTH-1:0]        alloc_rd_phys;
  logic [PREG_WIDTH-1:0]        alloc_old_rd;
  logic [PC_WIDTH-1:0]          alloc_pc;
  logic                         alloc_ready;
  logic [ROB_IDX_W-1:0]         rob_num;
  logic [NUM_CMP-1:0]           cmp_valid;
  logic [NUM_CMP*ROB_IDX_W-1:0] cmp_rob_num;
  logic                         retire_valid;
  logic [AREG_WIDTH-1:0]        retire_rd_arch;
  logic [PREG_WIDTH-1:0]        retire_rd_phys;
  logic [PC_WIDTH-1:0]          retire_pc;
  logic                         rob_push;
  logic [PREG_WIDTH-1:0]        rob_free_reg;
  logic                         empty;
  logic                         full;
  logic [ROB_IDX_W:0]           count;

  modport master (
    output alloc_valid, alloc_reg_write, alloc_rd_arch, alloc_rd_phys, alloc_old_rd, alloc_pc,
    output cmp_valid, cmp_rob_num,
    input  alloc_ready, rob_num, retire_valid, retire_rd_arch, retire_rd_phys, retire_pc,
    input  rob_push, rob_free_reg, empty, full, count
  );

  modport slave (
    input  alloc_valid, alloc_reg_write, alloc_rd_arch, alloc_rd_phys, alloc_old_rd, alloc_pc,
    input  cmp_valid, cmp_rob_num,
    output alloc_ready, rob_num, retire_valid, retire_rd_arch, retire_rd_phys, retire_pc,
    output rob_push, rob_free_reg, empty, full, count
  );

endinterface

// File: rtl/rob_cmp_decode.sv
// rtl/rob_cmp_decode.sv - folds the completion ports into a one-hot set of entries to mark done
module rob_cmp_decode
  import rob_pkg::*;
(
  input  logic [NUM_CMP-1:0]           cmp_valid,
  input  logic [NUM_CMP*ROB_IDX_W-1:0] cmp_rob_num,
  output logic [ROB_DEPTH-1:0]         done_set
);

  always_comb begin
    done_set = '0;
    for (int i = 0; i < NUM_CMP; i++) begin
      if (cmp_valid[i]) done_set[cmp_rob_num[i*ROB_IDX_W +: ROB_IDX_W]] = 1'b1;
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - circular in-order ROB: allocate at tail, complete by tag, retire one per cycle
// from the head. Defining ROB_FLUSH_EN adds a flush input that empties the buffer.
module reorder_buffer
  import rob_pkg::*;
(
  input logic clk,
  input logic rst,
`ifdef ROB_FLUSH_EN
  input logic flush,
`endif
  reorder_buffer_if.slave rob
);

  rob_payload_t         payload [ROB_DEPTH];
  logic [ROB_DEPTH-1:0] valid_q;
  logic [ROB_DEPTH-1:0] done_q;
  logic [ROB_DEPTH-1:0] done_set;
  rob_idx_t             head;
  rob_idx_t             tail;
  logic [ROB_IDX_W:0]   count_q;
  rob_entry_t           head_e;
  rob_payload_t         new_pl;
  logic                 full_w;
  logic                 alloc_fire;
  logic                 retire_fire;
  logic                 flush_fire;
  logic                 push_w;

`ifdef ROB_FLUSH_EN
  assign flush_fire = flush;
`else
  assign flush_fire = 1'b0;
`endif

  rob_cmp_decode u_cmp_decode (
    .cmp_valid   (rob.cmp_valid),
    .cmp_rob_num (rob.cmp_rob_num),
    .done_set    (done_set)
  );

  // Occupancy alone decides full/empty so head==tail is never ambiguous.
  assign full_w      = (count_q == (ROB_IDX_W+1)'(ROB_DEPTH));
  assign alloc_fire  = rob.alloc_valid && !full_w;
  assign head_e      = '{valid: valid_q[head], done: done_q[head], data: payload[head]};
  assign retire_fire = head_e.valid && head_e.done;
  assign push_w      = retire_fire && head_e.data.reg_write && (head_e.data.rd_arch != '0);
  assign new_pl      = '{reg_write: rob.alloc_reg_write, rd_arch: rob.alloc_rd_arch,
                         rd_phys: rob.alloc_rd_phys, old_rd: rob.alloc_old_rd, pc: rob.alloc_pc};

  assign rob.alloc_ready = !full_w;
  assign rob.rob_num     = tail;
  assign rob.count       = count_q;
  assign rob.empty       = (count_q == '0);
  assign rob.full        = full_w;

  always_ff @(posedge clk) begin
    if (alloc_fire && !flush_fire) payload[tail] <= new_pl;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      done_q  <= '0;
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else if (flush_fire) begin
      valid_q <= '0;
      done_q  <= '0;
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      done_q <= done_q | (done_set & valid_q);
      if (retire_fire) begin
        valid_q[head] <= 1'b0;
        done_q[head]  <= 1'b0;
        head          <= head + rob_idx_t'(1);
      end
      if (alloc_fire) begin
        valid_q[tail] <= 1'b1;
        done_q[tail]  <= 1'b0;
        tail          <= tail + rob_idx_t'(1);
      end
      count_q <= count_q + (ROB_IDX_W+1)'(alloc_fire) - (ROB_IDX_W+1)'(retire_fire);
    end
  end

  // Retire outputs hold for exactly one cycle after the retiring edge and are zero otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rob.retire_valid   <= 1'b0;
      rob.retire_rd_arch <= '0;
      rob.retire_rd_phys <= '0;
      rob.retire_pc      <= '0;
      rob.rob_push       <= 1'b0;
      rob.rob_free_reg   <= '0;
    end else begin
      rob.retire_valid   <= retire_fire && !flush_fire;
      rob.retire_rd_arch <= (retire_fire && !flush_fire) ? head_e.data.rd_arch : '0;
      rob.retire_rd_phys <= (retire_fire && !flush_fire) ? head_e.data.rd_phys : '0;
      rob.retire_pc      <= (retire_fire && !flush_fire) ? head_e.data.pc : '0;
      rob.rob_push       <= push_w && !flush_fire;
      rob.rob_free_reg   <= (push_w && !flush_fire) ? head_e.data.old_rd : '0;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// tb/tb_reorder_buffer.sv - self-checking bench for reorder_buffer; build with ROB_FLUSH_EN to cover flush
module tb_reorder_buffer;
  import rob_pkg::*;

  logic clk   = 1'b0;
  logic rst   = 1'b0;
  logic flush = 1'b0;
  int   n_total = 0;
  int   n_pass  = 0;

  reorder_buffer_if rif ();

  always #5 clk = ~clk;

  reorder_buffer dut (
    .clk   (clk),
    .rst   (rst),
`ifdef ROB_FLUSH_EN
    .flush (flush),
`endif
    .rob   (rif)
  );

  typedef struct {
    int idx;
    bit rw;
    int arch;
    int phys;
    int old;
    int pc;
    bit done;
  } m_ent_t;

  m_ent_t mq[$];
  int alloc_total = 0;
  int exp_rv = 0, exp_arch = 0, exp_phys = 0, exp_pc = 0, exp_push = 0, exp_free = 0;

  function automatic void check(string name, longint act, longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endfunction

  function automatic void clear_exp();
    exp_rv = 0; exp_arch = 0; exp_phys = 0; exp_pc = 0; exp_push = 0; exp_free = 0;
  endfunction

  function automatic void model_reset();
    mq.delete();
    alloc_total = 0;
    clear_exp();
  endfunction

  // In-order queue of in-flight instructions; the oldest retires once it has been completed.
  function automatic void model_step();
    int     pre;
    bit     do_ret;
    m_ent_t r;
    m_ent_t n;
    pre = mq.size();
    clear_exp();
    if (flush) begin
      model_reset();
      return;
    end
    do_ret = (pre > 0) && mq[0].done;
    if (do_ret) r = mq[0];
    for (int p = 0; p < NUM_CMP; p++) begin
      if (rif.cmp_valid[p]) begin
        foreach (mq[j]) begin
          if (mq[j].idx == int'(rif.cmp_rob_num[p*ROB_IDX_W +: ROB_IDX_W])) mq[j].done = 1'b1;
        end
      end
    end
    if (do_ret) begin
      void'(mq.pop_front());
      exp_rv   = 1;
      exp_arch = r.arch;
      exp_phys = r.phys;
      exp_pc   = r.pc;
      exp_push = (r.rw && r.arch != 0) ? 1 : 0;
      exp_free = exp_push ? r.old : 0;
    end
    if (rif.alloc_valid && pre < ROB_DEPTH) begin
      n.idx  = alloc_total % ROB_DEPTH;
      n.rw   = rif.alloc_reg_write;
      n.arch = int'(rif.alloc_rd_arch);
      n.phys = int'(rif.alloc_rd_phys);
      n.old  = int'(rif.alloc_old_rd);
      n.pc   = int'(rif.alloc_pc);
      n.done = 1'b0;
      mq.push_back(n);
      alloc_total++;
    end
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) model_reset();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("count", rif.count, mq.size());
      check("empty", rif.empty, mq.size() == 0);
      check("full", rif.full, mq.size() == ROB_DEPTH);
      check("alloc_ready", rif.alloc_ready, mq.size() != ROB_DEPTH);
      check("rob_num", rif.rob_num, alloc_total % ROB_DEPTH);
      check("retire_valid", rif.retire_valid, exp_rv);
      check("retire_rd_arch", rif.retire_rd_arch, exp_arch);
      check("retire_rd_phys", rif.retire_rd_phys, exp_phys);
      check("retire_pc", rif.retire_pc, exp_pc);
      check("rob_push", rif.rob_push, exp_push);
      check("rob_free_reg", rif.rob_free_reg, exp_free);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    rif.alloc_valid     = 1'b0;
    rif.alloc_reg_write = 1'b0;
    rif.alloc_rd_arch   = '0;
    rif.alloc_rd_phys   = '0;
    rif.alloc_old_rd    = '0;
    rif.alloc_pc        = '0;
    rif.cmp_valid       = '0;
    rif.cmp_rob_num     = '0;
    flush               = 1'b0;
  endtask

  task automatic set_alloc(input bit rw, input int arch, input int phys, input int old, input int pc);
    rif.alloc_valid     = 1'b1;
    rif.alloc_reg_write = rw;
    rif.alloc_rd_arch   = AREG_WIDTH'(arch);
    rif.alloc_rd_phys   = PREG_WIDTH'(phys);
    rif.alloc_old_rd    = PREG_WIDTH'(old);
    rif.alloc_pc        = PC_WIDTH'(pc);
  endtask

  task automatic set_cmp(input int p, input int idx);
    rif.cmp_valid[p] = 1'b1;
    rif.cmp_rob_num[p*ROB_IDX_W +: ROB_IDX_W] = ROB_IDX_W'(idx);
  endtask

  initial begin
    clear_in();
    tick(); tick();
    check("rst_count", rif.count, 0);
    check("rst_empty", rif.empty, 1);
    check("rst_full", rif.full, 0);
    check("rst_alloc_ready", rif.alloc_ready, 1);
    check("rst_rob_num", rif.rob_num, 0);
    check("rst_retire_valid", rif.retire_valid, 0);
    check("rst_rob_push", rif.rob_push, 0);
    rst = 1'b1;
    tick();

    for (int k = 0; k < 3; k++) begin
      check("t1_rob_num", rif.rob_num, k);
      set_alloc(1'b1, k + 1, 10 + k, 33 + k, 'h100 + 4 * k);
      tick();
    end
    clear_in();
    check("t1_count", rif.count, 3);
    tick();
    check("t1_no_retire", rif.retire_valid, 0);

    set_cmp(0, 0);
    tick();
    clear_in();
    check("t2_not_yet", rif.retire_valid, 0);
    tick();
    check("t2_retire_valid", rif.retire_valid, 1);
    check("t2_rob_push", rif.rob_push, 1);
    check("t2_free_reg", rif.rob_free_reg, 33);
    tick();
    check("t2_blocked", rif.retire_valid, 0);

    set_cmp(1, 2);
    tick();
    clear_in();
    tick(); tick();
    check("t3_wait_head", rif.retire_valid, 0);
    check("t3_count", rif.count, 2);
    set_cmp(2, 1);
    set_cmp(0, 1);
    tick();
    clear_in();
    tick();
    check("t3_free_34", rif.rob_free_reg, 34);
    tick();
    check("t3_free_35", rif.rob_free_reg, 35);
    tick();
    check("t3_empty", rif.empty, 1);

    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();

    for (int k = 0; k < ROB_DEPTH; k++) begin
      check("t4_fill_rob_num", rif.rob_num, k);
      set_alloc(1'b1, (k % 31) + 1, k, 63 - k, 4 * k);
      tick();
    end
    clear_in();
    check("t4_full", rif.full, 1);
    check("t4_alloc_ready", rif.alloc_ready, 0);
    check("t4_count", rif.count, 64);
    set_alloc(1'b1, 3, 3, 3, 3);
    tick();
    clear_in();
    check("t4_65th_count", rif.count, 64);
    check("t4_65th_rob_num", rif.rob_num, 0);
    for (int j = 0; j < ROB_DEPTH; j += 3) begin
      for (int p = 0; p < NUM_CMP; p++) begin
        if (j + p < ROB_DEPTH) set_cmp(p, j + p);
      end
      tick();
      clear_in();
    end
    for (int c = 0; c < 300 && !rif.empty; c++) tick();
    check("t4_drain_empty", rif.empty, 1);
    tick();

    for (int k = 0; k < 10; k++) begin
      if (k == 0) check("t5_wrap_rob_num", rif.rob_num, 0);
      set_alloc(1'b1, (k == 0) ? 0 : k, 20 + k, 50 + k, 'h200 + k);
      tick();
    end
    clear_in();
    set_cmp(0, 0);
    tick();
    clear_in();
    check("t5_count_before", rif.count, 10);
    set_alloc(1'b1, 7, 30, 60, 'h300);
    tick();
    clear_in();
    check("t5_count_same", rif.count, 10);
    check("t5_retire_valid", rif.retire_valid, 1);
    check("t5_rd0_no_push", rif.rob_push, 0);
    check("t5_rd0_free", rif.rob_free_reg, 0);

    set_cmp(0, 1); set_cmp(1, 2); set_cmp(2, 3);
    tick();
    clear_in();
    set_cmp(0, 4); set_cmp(1, 5);
    tick();
    clear_in();
    tick(); tick(); tick(); tick();
    check("t6_count5", rif.count, 5);
    set_cmp(0, 6);
    tick();
    clear_in();
    #3 rst = 1'b0;
    #2;
    check("t6_rst_count", rif.count, 0);
    check("t6_rst_empty", rif.empty, 1);
    check("t6_rst_retire_valid", rif.retire_valid, 0);
    check("t6_rst_push", rif.rob_push, 0);
    check("t6_rst_rob_num", rif.rob_num, 0);
    tick();
    rst = 1'b1;
    tick();
    check("t6_after_push", rif.rob_push, 0);
    tick();
    check("t6_after_retire", rif.retire_valid, 0);

`ifdef ROB_FLUSH_EN
    for (int k = 0; k < 7; k++) begin
      set_alloc(1'b1, k + 1, k, 40 + k, k);
      tick();
    end
    clear_in();
    set_cmp(0, 0);
    tick();
    clear_in();
    check("t7_count7", rif.count, 7);
    flush = 1'b1;
    set_alloc(1'b1, 9, 9, 9, 9);
    set_cmp(1, 1);
    tick();
    clear_in();
    check("t7_flush_count", rif.count, 0);
    check("t7_flush_empty", rif.empty, 1);
    check("t7_flush_retire", rif.retire_valid, 0);
    check("t7_flush_push", rif.rob_push, 0);
    check("t7_flush_rob_num", rif.rob_num, 0);
    tick();
    check("t7_after_retire", rif.retire_valid, 0);
`endif

    tick(); tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
